// File: rtl/tcdm_arb_pkg.sv
// Shared constants and helpers for the TCDM round-robin arbiter.
// The conflict counter width is used only when TCDM_ARB_PERF_CNT_EN is defined.
package tcdm_arb_pkg;

    localparam int CNT_W = 32;

    function automatic int id_w(input int nm);
        return (nm <= 2) ? 1 : $clog2(nm);
    endfunction

endpackage

// File: rtl/tcdm_rr_picker.sv
// Rotate-priority picker: returns the first requester at or after rr_ptr,
// wrapping from NM-1 back to 0.
module tcdm_rr_picker
    import tcdm_arb_pkg::*;
#(
    parameter int NM   = 4,
    parameter int ID_W = id_w(NM)
) (
    input  logic [NM-1:0]   req_i,
    input  logic [ID_W-1:0] rr_ptr_i,
    output logic [ID_W-1:0] sel_o,
    output logic            any_req_o
);

    logic [2*NM-1:0] req_dbl;
    logic [NM-1:0]   req_rot;

    assign req_dbl   = {req_i, req_i};
    assign req_rot   = NM'(req_dbl >> rr_ptr_i);
    assign any_req_o = |req_i;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int sum;
        sel_o = '0;
        sum   = 0;
        for (int k = NM - 1; k >= 0; k--) begin
            sum = int'(rr_ptr_i) + k;
            if (sum >= NM) begin
                sum = sum - NM;
            end
            if (req_rot[k]) begin
                sel_o = ID_W'(sum);
            end
        end
    end

endmodule

// File: rtl/tcdm_rr_arbiter.sv
// N-to-1 round-robin TCDM arbiter with single-cycle response routing.
// Define TCDM_ARB_PERF_CNT_EN to add a saturating request-conflict counter.
module tcdm_rr_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int NM   = 4,
    parameter int ID_W = id_w(NM)
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef TCDM_ARB_PERF_CNT_EN
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] conflict_cnt_o,
`endif
    input  logic [NM-1:0]    tcdm_in_req_i,
    output logic [NM-1:0]    tcdm_in_gnt_o,
    input  logic [NM*32-1:0] tcdm_in_add_i,
    input  logic [NM-1:0]    tcdm_in_wen_i,
    input  logic [NM*4-1:0]  tcdm_in_be_i,
    input  logic [NM*32-1:0] tcdm_in_data_i,
    output logic [NM*32-1:0] tcdm_in_r_data_o,
    output logic [NM-1:0]    tcdm_in_r_valid_o,
    output logic             tcdm_out_req_o,
    input  logic             tcdm_out_gnt_i,
    output logic [31:0]      tcdm_out_add_o,
    output logic             tcdm_out_wen_o,
    output logic [3:0]       tcdm_out_be_o,
    output logic [31:0]      tcdm_out_data_o,
    input  logic [31:0]      tcdm_out_r_data_i,
    input  logic             tcdm_out_r_valid_i
);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic            resp_pend_q, resp_pend_d;
    logic [ID_W-1:0] sel;
    logic            any_req;
    logic            hs;

    tcdm_rr_picker #(
        .NM   (NM),
        .ID_W (ID_W)
    ) i_picker (
        .req_i     (tcdm_in_req_i),
        .rr_ptr_i  (rr_ptr_q),
        .sel_o     (sel),
        .any_req_o (any_req)
    );

    assign tcdm_out_req_o  = any_req;
    assign tcdm_out_add_o  = tcdm_in_add_i[32*sel +: 32];
    assign tcdm_out_wen_o  = tcdm_in_wen_i[sel];
    assign tcdm_out_be_o   = tcdm_in_be_i[4*sel +: 4];
    assign tcdm_out_data_o = tcdm_in_data_i[32*sel +: 32];
    assign hs              = any_req & tcdm_out_gnt_i;

    always_comb begin
        tcdm_in_gnt_o     = '0;
        tcdm_in_r_valid_o = '0;
        tcdm_in_r_data_o  = '0;
        for (int i = 0; i < NM; i++) begin
            tcdm_in_gnt_o[i]     = tcdm_out_gnt_i & tcdm_in_req_i[i] & (sel == ID_W'(i));
            tcdm_in_r_valid_o[i] = tcdm_out_r_valid_i & resp_pend_q & (resp_id_q == ID_W'(i));
            if (tcdm_in_r_valid_o[i]) begin
                tcdm_in_r_data_o[32*i +: 32] = tcdm_out_r_data_i;
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        resp_id_d   = resp_id_q;
        resp_pend_d = hs;
        if (hs) begin
            rr_ptr_d  = (sel == ID_W'(NM - 1)) ? '0 : sel + 1'b1;
            resp_id_d = sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            resp_id_q   <= '0;
            resp_pend_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            resp_id_q   <= resp_id_d;
            resp_pend_q <= resp_pend_d;
        end
    end

`ifdef TCDM_ARB_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conflict;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign conflict       = |(tcdm_in_req_i & (tcdm_in_req_i - 1'b1));
    assign conflict_cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (conflict && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule
